spi_reg_slave: RTL

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_slave_pkg.sv | 9 +
 rtl/spi_reg_slave_sync_edge.sv | 20 ++
 rtl/spi_reg_slave.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_reg_slave_pkg.sv
// spi_reg_slave_pkg: frame geometry, state encoding and defaults shared by the SPI register slave
package spi_reg_slave_pkg;
    localparam int         FRAME_LEN       = 24;
    localparam int         INSTR_LEN       = 16;
    localparam int         RW_BIT          = 23;
    localparam logic [1:0] W1W0_LEGAL      = 2'b00;
    localparam logic [7:0] CHIP_ID_DEFAULT = 8'h88;
    typedef enum logic [2:0] {IDLE, INSTR, WR_DATA, RD_DATA, DONE} state_t;
endpackage

// File: rtl/spi_reg_slave_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer plus a third flop for rise/fall detection
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {3{RST_VAL}};
        else        sync_q <= {sync_q[1:0], d_i};
    end
    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: 3-wire SPI slave giving read/write access to a small 8-bit register file
module spi_reg_slave
    import spi_reg_slave_pkg::*;
#(
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] CHIP_ID  = CHIP_ID_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csb,
    input  logic                  sclk,
    input  logic                  sdio_i,
    output logic                  sdio_o,
    output logic                  sdio_oe,
    output logic                  reg_wr_vld,
    output logic [12:0]           reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  frame_err,
    output logic [NUM_REGS*8-1:0] reg_dump
);
    localparam int          AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [12:0] NUM_REGS_A = 13'(NUM_REGS);
    localparam int          RW_POS     = RW_BIT - (FRAME_LEN - INSTR_LEN);

    logic       csb_s, csb_rise, csb_fall, sclk_s, sclk_rise, sclk_fall, sdio_s, unused;
    logic [1:0] sdio_q;
    state_t     state_q;
    logic [4:0] cnt_q;
    logic [14:0] shift_q;
    logic [7:0] out_q, rd_val, wdata;
    logic [15:0] instr;
    logic       wr_ok;
    logic [7:0] regs_q [NUM_REGS];
    logic       sdio_o_q, sdio_oe_q, reg_wr_vld_q, frame_err_q;
    logic [12:0] reg_addr_q;
    logic [7:0] reg_wdata_q;

    spi_sync_edge #(.RST_VAL(1'b1)) u_csb (
        .clk(clk), .rst_n(rst_n), .d_i(csb), .q_o(csb_s), .rise_o(csb_rise), .fall_o(csb_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    assign unused = ^{csb_rise, sclk_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sdio_q <= 2'b00;
        else        sdio_q <= {sdio_q[0], sdio_i};
    end
    assign sdio_s = sdio_q[1];

    always_comb begin
        instr  = {shift_q, sdio_s};
        wdata  = {shift_q[6:0], sdio_s};
        wr_ok  = (reg_addr_q != 13'd1) && (reg_addr_q < NUM_REGS_A);
        rd_val = (reg_addr_q == 13'd1) ? CHIP_ID :
                 (reg_addr_q < NUM_REGS_A) ? regs_q[reg_addr_q[AW-1:0]] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            out_q        <= '0;
            sdio_o_q     <= 1'b0;
            sdio_oe_q    <= 1'b0;
            reg_wr_vld_q <= 1'b0;
            frame_err_q  <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            reg_wr_vld_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (csb_s) begin
                // csb high before the frame completed is an abort
                if (state_q inside {INSTR, WR_DATA, RD_DATA}) frame_err_q <= 1'b1;
                state_q   <= IDLE;
                sdio_oe_q <= 1'b0;
                sdio_o_q  <= 1'b0;
            end else begin
                if (sclk_rise && (state_q inside {INSTR, WR_DATA, RD_DATA})) begin
                    shift_q <= {shift_q[13:0], sdio_s};
                    cnt_q   <= cnt_q + 5'd1;
                end
                case (state_q)
                    IDLE: if (csb_fall) begin
                        state_q <= INSTR;
                        cnt_q   <= '0;
                    end
                    INSTR: if (sclk_rise && cnt_q == 5'(INSTR_LEN - 1)) begin
                        if (instr[RW_POS-1 -: 2] != W1W0_LEGAL) begin
                            frame_err_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            reg_addr_q <= instr[12:0];
                            state_q    <= instr[RW_POS] ? RD_DATA : WR_DATA;
                        end
                    end
                    WR_DATA: if (sclk_rise && cnt_q == 5'(FRAME_LEN - 1)) begin
                        reg_wr_vld_q <= 1'b1;
                        reg_wdata_q  <= wdata;
                        if (wr_ok) regs_q[reg_addr_q[AW-1:0]] <= wdata;
                        state_q <= DONE;
                    end
                    RD_DATA: begin
                        if (sclk_rise && cnt_q == 5'(FRAME_LEN - 1)) state_q <= DONE;
                        // first falling edge loads the read value, later ones shift it out
                        if (sclk_fall) begin
                            sdio_oe_q <= 1'b1;
                            sdio_o_q  <= sdio_oe_q ? out_q[7] : rd_val[7];
                            out_q     <= sdio_oe_q ? {out_q[6:0], 1'b0} : {rd_val[6:0], 1'b0};
                        end
                    end
                    DONE: if (sclk_fall) begin
                        sdio_oe_q <= 1'b0;
                        sdio_o_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_dump
        assign reg_dump[g*8 +: 8] = regs_q[g];
    end

    assign sdio_o     = sdio_o_q;
    assign sdio_oe    = sdio_oe_q;
    assign reg_wr_vld = reg_wr_vld_q;
    assign frame_err  = frame_err_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
endmodule
